vec_mem_sequencer: RTL and testbench

Memory-stage sequencer for the vector pipeline, directly downstream of the EX/MEM pipeline register. It consumes the M-stage control and data (per-lane addresses, store data, load/store strobes, vector/scalar flag) and serialises each access onto a single-ported, word-wide data memory. It stalls the pipeline until every lane is done, and presents the assembled 16-lane load result to the MEM/WB register.

---
 rtl/vec_pkg.sv | 18 +
 rtl/vec_mem_sequencer.sv | 145 ++++++++++++++
 tb/tb_vec_mem_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/vec_pkg.sv
// Shared vector-pipeline definitions: geometry constants, the lane vector type
// and the memory-stage sequencer state encoding.
package vec_pkg;

  localparam int LANES  = 16;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;

  typedef logic [LANES-1:0][DATA_W-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_fsm_t;

endpackage

// File: rtl/vec_mem_sequencer.sv
// Memory-stage sequencer: serialises scalar/vector loads and stores onto a
// single-ported word memory, stalling the pipeline until every lane is done.
module vec_mem_sequencer #(
  parameter int LANES  = vec_pkg::LANES,
  parameter int DATA_W = vec_pkg::DATA_W,
  parameter int ADDR_W = vec_pkg::ADDR_W
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [LANES-1:0][DATA_W-1:0] ALUResultM,
  input  logic [LANES-1:0][DATA_W-1:0] WriteDataM,
  input  logic                         MemtoRegM,
  input  logic                         MemWriteM,
  input  logic                         v_s_m,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic                         mem_we,
  output logic                         mem_re,
  output logic [LANES-1:0][DATA_W-1:0] ReadDataM,
  output logic                         StallM
);
  import vec_pkg::*;

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  mem_fsm_t                     state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         tag_vld_q;
  logic [CNT_W-1:0]             tag_idx_q;
  logic [LANES-1:0][DATA_W-1:0] rd_q;

  logic             req;
  logic             is_store;
  logic             is_load;
  logic [CNT_W-1:0] last;
  logic             stall;
  logic             unused_addr_bits;

  // A simultaneous load+store request is executed as a store only.
  assign req      = MemWriteM | MemtoRegM;
  assign is_store = MemWriteM;
  assign is_load  = MemtoRegM & ~MemWriteM;
  assign last     = v_s_m ? CNT_W'(LANES - 1) : '0;

  // Next-state and memory-port decode; strobes are only ever active in RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall   = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        stall    = 1'b1;
        mem_addr = ALUResultM[cnt_q][ADDR_W-1:0];
        if (is_store) begin
          mem_we    = 1'b1;
          mem_wdata = WriteDataM[cnt_q];
        end else begin
          mem_re = is_load;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == last) begin
          state_d = is_store ? DONE : WAIT;
        end else begin
          state_d = RUN;
        end
      end
      WAIT: begin
        stall   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The stall must fall together with reset even while a request is presented.
  assign StallM = stall & ~RST;

  // Only the low ADDR_W bits of each lane address reach the memory.
  always_comb begin
    unused_addr_bits = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      unused_addr_bits = unused_addr_bits ^ (^ALUResultM[i][DATA_W-1:ADDR_W]);
    end
  end

  // FSM state and lane counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Issue tag follows each read strobe so the returning word lands in its lane.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tag_vld_q <= 1'b0;
      tag_idx_q <= '0;
    end else begin
      tag_vld_q <= (state_q == RUN) & is_load;
      tag_idx_q <= cnt_q;
    end
  end

  // Load result assembly; a scalar load zeroes the upper lanes when it starts.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_q <= '0;
    end else begin
      if ((state_q == IDLE) && is_load && !v_s_m) begin
        for (int i = 1; i < LANES; i++) begin
          rd_q[i] <= '0;
        end
      end
      if (tag_vld_q) begin
        rd_q[tag_idx_q] <= mem_rdata;
      end
    end
  end

  assign ReadDataM = rd_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Randomised self-checking bench for vec_mem_sequencer: a word memory model
// answers the DUT, and a lane-level reference predicts results and timing.
module tb_vec_mem_sequencer;
  import vec_pkg::*;

  logic                CLK;
  logic                RST;
  lane_vec_t           ALUResultM;
  lane_vec_t           WriteDataM;
  logic                MemtoRegM;
  logic                MemWriteM;
  logic                v_s_m;
  logic [DATA_W-1:0]   mem_rdata;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_we;
  logic                mem_re;
  lane_vec_t           ReadDataM;
  logic                StallM;

  int n_checks;
  int n_errors;

  logic [DATA_W-1:0] mem     [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  lane_vec_t         exp_rd;
  bit                mem_init_q;

  vec_mem_sequencer dut (
    .CLK        (CLK),
    .RST        (RST),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .v_s_m      (v_s_m),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single-ported word memory, read data one cycle after the read strobe.
  always @(posedge CLK) begin
    if (!mem_init_q) begin
      for (int a = 0; a < (1 << ADDR_W); a++) mem[a] <= DATA_W'(a);
      mem[5]     <= 32'hDEADBEEF;
      mem_init_q <= 1'b1;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one M-stage op, follow it to its first non-stalled cycle, check all.
  task automatic do_op(input string nm, input logic ld, input logic st, input logic vs,
                       input lane_vec_t a, input lane_vec_t wd);
    int  nl, exp_stall, stalls, nwe, nre, first_stall;
    bit  done, is_ld, is_st;
    is_st = st;
    is_ld = ld & ~st;
    nl    = vs ? LANES : 1;
    ALUResultM = a; WriteDataM = wd; MemtoRegM = ld; MemWriteM = st; v_s_m = vs;
    if (is_st)      exp_stall = nl + 1;
    else if (is_ld) exp_stall = nl + 2;
    else            exp_stall = 0;
    if (is_ld) begin
      if (!vs) exp_rd = '0;
      for (int i = 0; i < nl; i++) exp_rd[i] = ref_mem[a[i][ADDR_W-1:0]];
    end
    if (is_st) begin
      for (int i = 0; i < nl; i++) ref_mem[a[i][ADDR_W-1:0]] = wd[i];
    end
    stalls = 0; nwe = 0; nre = 0; done = 1'b0; first_stall = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      if (c == 0) first_stall = int'(StallM);
      if (StallM) begin
        stalls++;
        if (mem_we) begin
          if (nwe < LANES) begin
            check_eq({nm, " we_addr"}, 32'(mem_addr), 32'(a[nwe][ADDR_W-1:0]));
            check_eq({nm, " we_data"}, mem_wdata, wd[nwe]);
          end
          nwe++;
        end
        if (mem_re) begin
          if (nre < LANES) check_eq({nm, " re_addr"}, 32'(mem_addr), 32'(a[nre][ADDR_W-1:0]));
          nre++;
        end
      end else begin
        done = 1'b1;
      end
    end
    check_eq({nm, " first_stall"}, 32'(first_stall), (exp_stall > 0) ? 32'd1 : 32'd0);
    check_eq({nm, " stall_cycles"}, 32'(stalls), 32'(exp_stall));
    check_eq({nm, " we_count"}, 32'(nwe), is_st ? 32'(nl) : 32'd0);
    check_eq({nm, " re_count"}, 32'(nre), is_ld ? 32'(nl) : 32'd0);
    check_eq({nm, " done_strobes"}, {30'd0, mem_we, mem_re}, 32'd0);
    for (int i = 0; i < LANES; i++) check_eq({nm, " rd_lane"}, ReadDataM[i], exp_rd[i]);
    @(posedge CLK);
    #1;
    ALUResultM = '0; WriteDataM = '0; MemtoRegM = 1'b0; MemWriteM = 1'b0; v_s_m = 1'b0;
  endtask

  initial begin
    lane_vec_t a, wd;
    int nmis;
    n_checks = 0; n_errors = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = DATA_W'(i);
    ref_mem[5] = 32'hDEADBEEF;
    exp_rd = '0;
    RST = 1'b1;
    ALUResultM = '0; WriteDataM = '0; MemtoRegM = 1'b0; MemWriteM = 1'b0; v_s_m = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("rst_stall", {31'd0, StallM}, 32'd0);
    check_eq("rst_strobes", {30'd0, mem_we, mem_re}, 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_wdata", mem_wdata, 32'd0);
    check_eq("rst_rdata", {31'd0, |ReadDataM}, 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Fill ReadDataM first so the scalar load's lane clearing is observable.
    for (int i = 0; i < LANES; i++) begin a[i] = $urandom; wd[i] = $urandom; end
    do_op("vld_rand", 1'b1, 1'b0, 1'b1, a, wd);

    a = '0; a[0] = 32'd5;
    do_op("sld_5", 1'b1, 1'b0, 1'b0, a, '0);

    for (int i = 0; i < LANES; i++) a[i] = 32'h10F - 32'(i);
    do_op("vld_rev", 1'b1, 1'b0, 1'b1, a, '0);

    for (int i = 0; i < LANES; i++) begin a[i] = $urandom; wd[i] = $urandom; end
    do_op("alu", 1'b0, 1'b0, 1'b1, a, wd);

    for (int i = 0; i < LANES; i++) begin a[i] = 32'h100 + 32'(i); wd[i] = 32'(i * 3); end
    do_op("vst_100", 1'b0, 1'b1, 1'b1, a, wd);

    for (int i = 0; i < LANES; i++) a[i] = 32'h100 + 32'(i);
    do_op("vld_back", 1'b1, 1'b0, 1'b1, a, '0);

    for (int i = 0; i < LANES; i++) begin a[i] = 32'h200 + 32'(i); wd[i] = $urandom; end
    do_op("vst_b2b", 1'b0, 1'b1, 1'b1, a, wd);

    for (int n = 0; n < 14; n++) begin
      logic ld, st, vs;
      ld = 1'($urandom); st = 1'($urandom); vs = 1'($urandom);
      for (int i = 0; i < LANES; i++) begin a[i] = $urandom; wd[i] = $urandom; end
      do_op("rand_op", ld, st, vs, a, wd);
    end

    // Reset in cycle 6 of a vector store: lanes 0..4 are already written.
    for (int i = 0; i < LANES; i++) begin a[i] = 32'h300 + 32'(i); wd[i] = $urandom; end
    ALUResultM = a; WriteDataM = wd; MemWriteM = 1'b1; MemtoRegM = 1'b0; v_s_m = 1'b1;
    for (int i = 0; i < 5; i++) ref_mem[a[i][ADDR_W-1:0]] = wd[i];
    repeat (7) @(negedge CLK);
    check_eq("pre_rst_we", {31'd0, mem_we}, 32'd1);
    RST = 1'b1;
    #1;
    exp_rd = '0;
    check_eq("rst_mid_we", {31'd0, mem_we}, 32'd0);
    check_eq("rst_mid_stall", {31'd0, StallM}, 32'd0);
    check_eq("rst_mid_rdata", {31'd0, |ReadDataM}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    ALUResultM = '0; WriteDataM = '0; MemWriteM = 1'b0; v_s_m = 1'b0;
    @(posedge CLK); #1;
    check_eq("post_rst_stall", {31'd0, StallM}, 32'd0);

    a = '0; wd = '0; a[0] = 32'h3F0; wd[0] = 32'hCAFE_F00D;
    do_op("sst_post_rst", 1'b0, 1'b1, 1'b0, a, wd);

    @(negedge CLK);
    nmis = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) if (mem[i] !== ref_mem[i]) nmis++;
    check_eq("mem_image", 32'(nmis), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
